// File: rtl/cal_sweep_ctrl.sv
// Calibration sweep sequencer: steps the DAC override through a setpoint ladder, settles, averages 4 ADC lanes.
// Define CAL_SWEEP_BIDIR_EN to run the ladder back down after the top step (res_step[7] marks descent).

module cal_sweep_lane #(
  parameter int W        = 16,
  parameter int AVG_LOG2 = 6
) (
  input  logic                clk_256fs,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                cap,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] avg
);
  localparam int AW = W + AVG_LOG2;

  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic signed [W-1:0]  avg_q, avg_d;

  always_comb begin
    sum   = acc_q + AW'(sample);
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum;
    // The capture includes the sample arriving on the final tick.
    avg_d = avg_q;
    if (cap) avg_d = W'(sum >>> AVG_LOG2);
  end

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
    end
  end

  assign avg = avg_q;
endmodule

module cal_sweep_ctrl #(
  parameter int W        = 16,
  parameter int N_STEPS  = 8,
  parameter int SETTLE   = 64,
  parameter int AVG_LOG2 = 6
) (
  input  logic         clk_256fs,
  input  logic         rst_n,
  input  logic         clk_fs,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] start_value,
  input  logic [W-1:0] step_size,
  input  logic [W-1:0] sample_adc0,
  input  logic [W-1:0] sample_adc1,
  input  logic [W-1:0] sample_adc2,
  input  logic [W-1:0] sample_adc3,
  output logic [W-1:0] force_dac_output,
  output logic         busy,
  output logic         done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [7:0]   res_step,
  output logic [W-1:0] res_avg0,
  output logic [W-1:0] res_avg1,
  output logic [W-1:0] res_avg2,
  output logic [W-1:0] res_avg3
);
  localparam int        NUM_LANES   = 4;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] AVG_LAST    = 16'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]  LAST_STEP   = 8'(N_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_REPORT} state_t;

  state_t         state_q, state_d;
  logic           clk_fs_q, fs_tick;
  logic [W-1:0]   sp_q, sp_d, ss_q, ss_d, dac_q, dac_d;
  logic [7:0]     step_q, step_d, res_step_q, res_step_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           dir_q, dir_d, busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic           lane_clr, lane_en, lane_cap;

  logic [NUM_LANES-1:0][W-1:0] smp, avg;

  assign fs_tick = clk_fs & ~clk_fs_q;
  assign smp     = {sample_adc3, sample_adc2, sample_adc1, sample_adc0};

  assign lane_clr = (state_q != S_ACCUM);
  assign lane_en  = (state_q == S_ACCUM) & fs_tick & ~abort;
  assign lane_cap = lane_en & (cnt_q == AVG_LAST);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    ss_d       = ss_q;
    step_d     = step_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    res_step_d = res_step_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start && !abort) begin
        sp_d    = start_value;
        ss_d    = step_size;
        step_d  = '0;
        dir_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (fs_tick) begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCUM;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_ACCUM: if (fs_tick) begin
        if (cnt_q == AVG_LAST) begin
          cnt_d      = '0;
          state_d    = S_REPORT;
          valid_d    = 1'b1;
          res_step_d = step_q | {dir_q, 7'b0};
        end else cnt_d = cnt_q + 16'd1;
      end
      S_REPORT: if (res_ready) begin
        valid_d = 1'b0;
        state_d = S_SETTLE;
        if (!dir_q && step_q != LAST_STEP) begin
          step_d = step_q + 8'd1;
          sp_d   = sp_q + ss_q;
        end
`ifdef CAL_SWEEP_BIDIR_EN
        else if (!dir_q || step_q != 8'd0) begin
          dir_d  = 1'b1;
          step_d = step_q - 8'd1;
          sp_d   = sp_q - ss_q;
        end
`endif
        else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
    // Zero means "no override" downstream, so a zero setpoint is nudged to 1.
    busy_d = (state_d != S_IDLE);
    dac_d  = busy_d ? ((sp_d == '0) ? W'(1) : sp_d) : '0;
  end

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clk_fs_q   <= 1'b0;
      sp_q       <= '0;
      ss_q       <= '0;
      dac_q      <= '0;
      step_q     <= '0;
      res_step_q <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_fs_q   <= clk_fs;
      sp_q       <= sp_d;
      ss_q       <= ss_d;
      dac_q      <= dac_d;
      step_q     <= step_d;
      res_step_q <= res_step_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cal_sweep_lane #(.W(W), .AVG_LOG2(AVG_LOG2)) u_lane (
      .clk_256fs (clk_256fs),
      .rst_n     (rst_n),
      .clr       (lane_clr),
      .en        (lane_en),
      .cap       (lane_cap),
      .sample    (smp[g]),
      .avg       (avg[g])
    );
  end

  assign force_dac_output = dac_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign res_valid        = valid_q;
  assign res_step         = res_step_q;
  assign res_avg0         = avg[0];
  assign res_avg1         = avg[1];
  assign res_avg2         = avg[2];
  assign res_avg3         = avg[3];
endmodule

// File: tb/tb_cal_sweep_ctrl.sv
// Randomized bench for cal_sweep_ctrl: drives clk_fs ticks and ADC data, predicts setpoints and floor averages.
module tb_cal_sweep_ctrl;
  localparam int W = 16, N_STEPS = 3, SETTLE = 4, AVG_LOG2 = 2, NAVG = 1 << AVG_LOG2;
  typedef logic [3:0][15:0] smp_t;

  logic        clk = 0, rst_n = 0, clk_fs = 0, start = 0, abort = 0, res_ready = 0;
  logic [15:0] start_value = 0, step_size = 0;
  logic [15:0] sample_adc0 = 0, sample_adc1 = 0, sample_adc2 = 0, sample_adc3 = 0;
  logic [15:0] force_dac_output, res_avg0, res_avg1, res_avg2, res_avg3;
  logic        busy, done, res_valid;
  logic [7:0]  res_step;
  int errors = 0, checks = 0, n_done = 0;

  cal_sweep_ctrl #(.W(W), .N_STEPS(N_STEPS), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)) dut (
    .clk_256fs(clk), .rst_n(rst_n), .clk_fs(clk_fs), .start(start), .abort(abort),
    .start_value(start_value), .step_size(step_size),
    .sample_adc0(sample_adc0), .sample_adc1(sample_adc1), .sample_adc2(sample_adc2), .sample_adc3(sample_adc3),
    .force_dac_output(force_dac_output), .busy(busy), .done(done), .res_valid(res_valid),
    .res_ready(res_ready), .res_step(res_step),
    .res_avg0(res_avg0), .res_avg1(res_avg1), .res_avg2(res_avg2), .res_avg3(res_avg3)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sp(logic [15:0] sv, logic [15:0] ss, int k);
    int t;
    logic [15:0] v;
    t = int'($signed(sv)) + k * int'($signed(ss));
    v = t[15:0];
    return (v == 16'h0) ? 16'h0001 : v;
  endfunction

  function automatic logic [15:0] floor_avg(longint s);
    longint q;
    q = (s >= 0) ? s / NAVG : -((-s + NAVG - 1) / NAVG);
    return 16'(q);
  endfunction

  function automatic logic [15:0] gen(int mode, int j);
    case (mode)
      1: return 16'h0123;
      2: return (j == NAVG - 1) ? 16'hFFFE : 16'hFFFF;
      3: return 16'h7FFF;
      4: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic smp_t rnd4();
    smp_t s;
    for (int c = 0; c < 4; c++) s[c] = 16'($urandom);
    return s;
  endfunction

  // One clk_fs rising edge carrying s; inputs that must be ignored are scrambled around it.
  task automatic tick(input smp_t s);
    clk_fs = 1;
    {sample_adc3, sample_adc2, sample_adc1, sample_adc0} = s;
    start_value = 16'($urandom);
    step_size   = 16'($urandom);
    @(negedge clk);
    clk_fs = 0;
    {sample_adc3, sample_adc2, sample_adc1, sample_adc0} = rnd4();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic run_sweep(input logic [15:0] sv, input logic [15:0] ss, input int mode,
                           input int bp_step, input int bp_cycles, input int abort_step);
    logic [7:0]  order[$];
    logic [15:0] ea[4];
    longint      sums[4];
    smp_t        s;
    int          done0, bad, idx;
    for (int k = 0; k < N_STEPS; k++) order.push_back(8'(k));
`ifdef CAL_SWEEP_BIDIR_EN
    for (int k = N_STEPS - 2; k >= 0; k--) order.push_back(8'h80 | 8'(k));
`endif
    done0 = n_done;
    @(negedge clk);
    start_value = sv; step_size = ss; start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_start", busy, 1);
    foreach (order[i]) begin
      idx = int'(order[i][6:0]);
      chk("dac_step", force_dac_output, exp_sp(sv, ss, idx));
      if (i == abort_step) begin
        tick(rnd4());
        tick(rnd4());
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("abort_dac", force_dac_output, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_valid, 0);
        repeat (3) @(negedge clk);
        chk("abort_nostart", busy, 0);
        chk("abort_nodone", n_done, done0);
        return;
      end
      repeat (SETTLE) tick(rnd4());
      chk("valid_accum", res_valid, 0);
      for (int c = 0; c < 4; c++) sums[c] = 0;
      for (int j = 0; j < NAVG; j++) begin
        for (int c = 0; c < 4; c++) begin
          s[c] = gen(mode, j);
          sums[c] += longint'($signed(s[c]));
        end
        tick(s);
      end
      for (int c = 0; c < 4; c++) ea[c] = floor_avg(sums[c]);
      chk("res_valid", res_valid, 1);
      chk("res_step", res_step, order[i]);
      chk("res_avg0", res_avg0, ea[0]);
      chk("res_avg1", res_avg1, ea[1]);
      chk("res_avg2", res_avg2, ea[2]);
      chk("res_avg3", res_avg3, ea[3]);
      chk("dac_report", force_dac_output, exp_sp(sv, ss, idx));
      if (i == bp_step) begin
        bad = 0;
        repeat (bp_cycles) begin
          @(negedge clk);
          if (res_valid !== 1'b1 || res_step !== order[i] || res_avg0 !== ea[0] || res_avg1 !== ea[1] ||
              res_avg2 !== ea[2] || res_avg3 !== ea[3] || force_dac_output !== exp_sp(sv, ss, idx)) bad++;
        end
        chk("bp_hold", bad, 0);
      end
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
      chk("valid_drop", res_valid, 0);
      if (i == order.size() - 1) begin
        chk("end_dac", force_dac_output, 0);
        chk("end_busy", busy, 0);
        chk("done_pulse", done, 1);
        @(negedge clk);
        chk("done_once", done, 0);
        chk("done_count", n_done, done0 + 1);
      end else chk("busy_mid", busy, 1);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    start_value = 16'h1000; step_size = 16'h0800; start = 1;
    @(negedge clk);
    start = 0;
    repeat (SETTLE) tick(rnd4());
    tick(rnd4());
    tick(rnd4());
    chk("rst_pre_dac", force_dac_output, 16'h1000);
    #2 rst_n = 0;
    #1;
    chk("rst_dac", force_dac_output, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_step", res_step, 0);
    chk("rst_avg", {res_avg0, res_avg3}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (SETTLE + NAVG + 2) tick(rnd4());
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_valid", res_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("init_dac", force_dac_output, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_valid", res_valid, 0);
    chk("init_step", res_step, 0);
    chk("init_avg01", {res_avg0, res_avg1}, 0);
    chk("init_avg23", {res_avg2, res_avg3}, 0);
    rst_n = 1;
    run_sweep(16'h1000, 16'h0800, 1, -1, 0, -1);
    run_sweep(16'h7FF0, 16'h0010, 0, 1, 5, -1);
    run_sweep(16'hFFF0, 16'h0010, 2, -1, 0, -1);
    run_sweep(16'($urandom), 16'($urandom), 3, 0, 100, -1);
    run_sweep(16'($urandom), 16'($urandom), 4, -1, 0, -1);
    repeat (3) run_sweep(16'($urandom), 16'($urandom), 0, $urandom_range(0, N_STEPS - 1), $urandom_range(0, 10), -1);
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_dac", force_dac_output, 0);
    run_sweep(16'h1000, 16'h0800, 0, -1, 0, 1);
    mid_reset();
    run_sweep(16'($urandom), 16'($urandom), 0, -1, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
